// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared framebuffer widths, write-queue state enum and helpers
package fb_pkg;

    localparam int FB_ADDR_W = 12;
    localparam int FB_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } wq_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/fb_wq_fifo.sv
// rtl/fb_wq_fifo.sv - write-queue storage with extra-bit pointers; FB_WQ_COALESCE_EN merges same-address pushes
module fb_wq_fifo
    import fb_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DATA_W = FB_DATA_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_push,
    input  logic                      i_pop,
    input  logic [ADDR_W-1:0]         i_addr,
    input  logic [DATA_W-1:0]         i_data,
    output logic [ADDR_W-1:0]         o_addr,
    output logic [DATA_W-1:0]         o_data,
    output logic [$clog2(DEPTH):0]    o_level,
    output logic [$clog2(DEPTH):0]    o_level_next,
    output logic                      o_full,
    output logic                      o_hit
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [ADDR_W-1:0] r_mem_addr [DEPTH];
    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic              w_empty;
    logic              w_wr_en;
    logic              w_rd_en;
    logic              w_hit;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_level = r_wr_ptr - r_rd_ptr;

`ifdef FB_WQ_COALESCE_EN
    logic [AW-1:0] w_newest;
    assign w_newest = r_wr_ptr[AW-1:0] - AW'(1);
    // The newest entry is only mergeable if it is not leaving the queue this cycle.
    assign w_hit = i_push && !w_empty && !(i_pop && o_level == PW'(1)) &&
                   (r_mem_addr[w_newest] == i_addr);
`else
    assign w_hit = 1'b0;
`endif

    assign w_rd_en      = i_pop && !w_empty;
    assign w_wr_en      = i_push && !w_hit && (!o_full || w_rd_en);
    assign o_level_next = o_level + PW'(w_wr_en) - PW'(w_rd_en);
    assign o_hit        = w_hit;
    assign o_addr       = r_mem_addr[r_rd_ptr[AW-1:0]];
    assign o_data       = r_mem_data[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem_addr[r_wr_ptr[AW-1:0]] <= i_addr;
            r_mem_data[r_wr_ptr[AW-1:0]] <= i_data;
        end
`ifdef FB_WQ_COALESCE_EN
        else if (w_hit) begin
            r_mem_data[w_newest] <= i_data;
        end
`endif
    end

endmodule

// File: rtl/fb_write_queue.sv
// rtl/fb_write_queue.sv - framebuffer write queue draining only during blanking; optional FB_WQ_COALESCE_EN
module fb_write_queue
    import fb_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DATA_W = FB_DATA_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   display_on,
    input  logic                   in_we,
    input  logic [ADDR_W-1:0]      in_addr,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   clr_ovf,
    output logic                   ram_we,
    output logic [ADDR_W-1:0]      ram_addr,
    output logic [DATA_W-1:0]      ram_d,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [7:0]             drop_cnt
);

    localparam int LW = $clog2(DEPTH) + 1;

    wq_state_t         r_state;
    wq_state_t         w_next_state;
    logic              w_pop;
    logic              w_full;
    logic              w_hit;
    logic              w_drop;
    logic [LW-1:0]     w_level_next;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;

    fb_wq_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .i_push       (in_we),
        .i_pop        (w_pop),
        .i_addr       (in_addr),
        .i_data       (in_data),
        .o_addr       (w_head_addr),
        .o_data       (w_head_data),
        .o_level      (level),
        .o_level_next (w_level_next),
        .o_full       (w_full),
        .o_hit        (w_hit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // Pop also requires the live display_on so a rising edge stops the drain in the same cycle.
    always_comb begin
        w_next_state = ST_IDLE;
        w_pop        = 1'b0;
        if (r_state == ST_DRAIN && !display_on) w_pop = 1'b1;
        if (w_level_next != LW'(0)) w_next_state = display_on ? ST_HOLD : ST_DRAIN;
    end

    assign w_drop = in_we && w_full && !w_pop && !w_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
        end else if (w_drop) begin
            overflow <= 1'b1;
            drop_cnt <= clr_ovf ? 8'd1 : sat_inc8(drop_cnt);
        end else if (clr_ovf) begin
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_d    <= '0;
        end else begin
            ram_we <= w_pop;
            if (w_pop) begin
                ram_addr <= w_head_addr;
                ram_d    <= w_head_data;
            end
        end
    end

endmodule
